// File: rtl/ultrasound_pkg.sv
// rtl/ultrasound_pkg.sv - shared types, defaults and helpers for the ultrasound receive path
//
// Purpose : demodulator state encoding, default sample/accumulator widths and
//           a sign-extension helper used by the accumulators.
// Ports   : none (package).
package ultrasound_pkg;

   localparam int DATA_W_DEF = 12;
   localparam int ACC_W_DEF  = 40;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_ACC  = 2'd2,
      ST_DONE = 2'd3
   } lockin_state_t;

   // Sign-extends the low data_w bits of data to 64 bits; callers truncate
   // the result to their accumulator width.
   function automatic logic [63:0] sext(input logic [63:0] data, input int unsigned data_w);
      return 64'($signed(data << (64 - data_w)) >>> (64 - data_w));
   endfunction

endpackage

// File: rtl/lockin_mac.sv
// rtl/lockin_mac.sv - signed +/- add accumulator with clear and enable
//
// Purpose : acc += pos ? +data : -data when en, cleared by clr.
// Ports   : clk_50M, rst_n (async active-low), clr, en, pos (sign select),
//           data [DATA_W] signed sample, acc [ACC_W] signed running sum.
module lockin_mac
   import ultrasound_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic                     clk_50M,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   input  logic                     pos,
   input  logic signed [DATA_W-1:0] data,
   output logic signed [ACC_W-1:0]  acc
);

   logic signed [ACC_W-1:0] ext;

   // Extending before negating keeps the most negative sample exact.
   assign ext = ACC_W'(sext(64'(data), DATA_W));

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= pos ? acc + ext : acc - ext;
      end
   end

endmodule

// File: rtl/quad_lockin_demod.sv
// rtl/quad_lockin_demod.sv - square-wave quadrature lock-in demodulator
//
// Purpose : integrates +/-adc_data into I and Q sums over NUM_PERIODS whole
//           periods of ref_0deg, starting at a rising edge of ref_0deg.
// Ports   : clk_50M, rst_n (async active-low); ref_0deg, ref_90deg references;
//           adc_data/adc_valid samples; start request; busy; i_sum, q_sum,
//           sample_cnt results with result_valid pulse; timeout_err pulse.
module quad_lockin_demod
   import ultrasound_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ACC_W       = ACC_W_DEF,
   parameter int NUM_PERIODS = 16,
   parameter int TIMEOUT_CYC = 1_000_000,
   parameter int CNT_W       = 32
) (
   input  logic                     clk_50M,
   input  logic                     rst_n,
   input  logic                     ref_0deg,
   input  logic                     ref_90deg,
   input  logic signed [DATA_W-1:0] adc_data,
   input  logic                     adc_valid,
   input  logic                     start,
   output logic                     busy,
   output logic signed [ACC_W-1:0]  i_sum,
   output logic signed [ACC_W-1:0]  q_sum,
   output logic [CNT_W-1:0]         sample_cnt,
   output logic                     result_valid,
   output logic                     timeout_err
);

   localparam int PER_W = $clog2(NUM_PERIODS + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [PER_W-1:0] LAST_PER = PER_W'(NUM_PERIODS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   lockin_state_t           state_q, state_d;
   logic                    ref_0deg_q;
   logic                    rise;
   logic [PER_W-1:0]        period_cnt;
   logic [TMO_W-1:0]        tmo_cnt;
   logic [CNT_W-1:0]        cnt_acc;
   logic                    in_window;
   logic                    close_win;
   logic                    tmo_hit;
   logic                    clr;
   logic                    mac_en;
   logic signed [ACC_W-1:0] acc_i, acc_q;

   assign rise   = ref_0deg & ~ref_0deg_q;
   assign clr    = (state_q == ST_IDLE);
   assign mac_en = in_window & adc_valid;

   assign busy         = (state_q == ST_ARM) || (state_q == ST_ACC);
   assign result_valid = (state_q == ST_DONE);

   // A rise always restarts the timeout, so it wins over an expiring count.
   always_comb begin
      state_d   = state_q;
      in_window = 1'b0;
      close_win = 1'b0;
      tmo_hit   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (rise) begin
               in_window = 1'b1;
               state_d   = ST_ACC;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_ACC: begin
            if (rise && period_cnt == LAST_PER) begin
               // Closing edge belongs to the next period: not accumulated.
               close_win = 1'b1;
               state_d   = ST_DONE;
            end else begin
               in_window = 1'b1;
               if (!rise && tmo_cnt == TMO_LAST) begin
                  tmo_hit = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ref_0deg_q  <= 1'b0;
         period_cnt  <= '0;
         tmo_cnt     <= '0;
         cnt_acc     <= '0;
         i_sum       <= '0;
         q_sum       <= '0;
         sample_cnt  <= '0;
         timeout_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         ref_0deg_q  <= ref_0deg;
         timeout_err <= tmo_hit;

         if (state_q == ST_IDLE || rise) tmo_cnt <= '0;
         else if (busy)                  tmo_cnt <= tmo_cnt + TMO_W'(1);

         if (state_q == ST_IDLE || (state_q == ST_ARM && rise)) period_cnt <= '0;
         else if (state_q == ST_ACC && rise && !close_win)      period_cnt <= period_cnt + PER_W'(1);

         if (clr)         cnt_acc <= '0;
         else if (mac_en) cnt_acc <= cnt_acc + CNT_W'(1);

         if (close_win) begin
            i_sum      <= acc_i;
            q_sum      <= acc_q;
            sample_cnt <= cnt_acc;
         end
      end
   end

   lockin_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac_i (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .clr     (clr),
      .en      (mac_en),
      .pos     (ref_0deg),
      .data    (adc_data),
      .acc     (acc_i)
   );

   lockin_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac_q (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .clr     (clr),
      .en      (mac_en),
      .pos     (ref_90deg),
      .data    (adc_data),
      .acc     (acc_q)
   );

endmodule

// File: tb/tb_quad_lockin_demod.sv
// tb/tb_quad_lockin_demod.sv - scoreboard bench for quad_lockin_demod
module tb_quad_lockin_demod;

   localparam int DW  = 12;
   localparam int AW  = 40;
   localparam int NP  = 2;
   localparam int TMO = 50;
   localparam int CW  = 32;

   logic                 clk_50M = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 ref_0deg = 1'b0;
   logic                 ref_90deg = 1'b0;
   logic signed [DW-1:0] adc_data = '0;
   logic                 adc_valid = 1'b0;
   logic                 start = 1'b0;
   logic                 busy;
   logic signed [AW-1:0] i_sum;
   logic signed [AW-1:0] q_sum;
   logic [CW-1:0]        sample_cnt;
   logic                 result_valid;
   logic                 timeout_err;

   quad_lockin_demod #(
      .DATA_W(DW), .ACC_W(AW), .NUM_PERIODS(NP), .TIMEOUT_CYC(TMO), .CNT_W(CW)
   ) dut (
      .clk_50M      (clk_50M),
      .rst_n        (rst_n),
      .ref_0deg     (ref_0deg),
      .ref_90deg    (ref_90deg),
      .adc_data     (adc_data),
      .adc_valid    (adc_valid),
      .start        (start),
      .busy         (busy),
      .i_sum        (i_sum),
      .q_sum        (q_sum),
      .sample_cnt   (sample_cnt),
      .result_valid (result_valid),
      .timeout_err  (timeout_err)
   );

   always #10 clk_50M = ~clk_50M;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference generator: 8-cycle period, ref_90deg lags ref_0deg by 2 cycles.
   int                   phase = 0;
   bit                   refs_en = 1'b0;
   int                   data_mode = 0;
   bit                   valid_toggle = 1'b0;
   logic signed [DW-1:0] tbl [8];
   int                   cyc = 0;

   always @(posedge clk_50M) begin
      cyc++;
      #1;
      if (refs_en) phase = (phase + 1) % 8;
      ref_0deg  = refs_en && (phase < 4);
      ref_90deg = refs_en && (phase >= 2) && (phase < 6);
      adc_valid = valid_toggle ? ~adc_valid : 1'b1;
      case (data_mode)
         0:       adc_data = 12'sd100;
         1:       adc_data = ref_0deg  ? 12'sd100 : -12'sd100;
         2:       adc_data = ref_90deg ? 12'sd100 : -12'sd100;
         3:       adc_data = ref_90deg ? -12'sd100 : 12'sd100;
         default: adc_data = tbl[phase];
      endcase
   end

   typedef struct {
      logic signed [63:0] i;
      logic signed [63:0] q;
      logic signed [63:0] n;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tmo_count = 0;
   int   tmo_cyc = 0;

   always @(negedge clk_50M) begin
      if (rst_n) begin
         if (result_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_result_valid", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               check("i_sum", i_sum, mon_e.i);
               check("q_sum", q_sum, mon_e.q);
               check("sample_cnt", {32'd0, sample_cnt}, mon_e.n);
               check("busy_at_valid", {63'd0, busy}, 0);
            end
         end
         if (timeout_err) begin
            tmo_count++;
            tmo_cyc = cyc;
         end
      end
   end

   int start_cyc = 0;

   task automatic pulse_start();
      @(posedge clk_50M);
      #1 start = 1'b1;
      start_cyc = cyc;
      @(posedge clk_50M);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 300) begin
         @(negedge clk_50M);
         n++;
      end
      if (n >= 300) check({tag, "_wait_expired"}, 0, 1);
   endtask

   task automatic measure(input string tag, input longint ei, input longint eq, input longint en);
      exp_t e;
      e.i = ei;
      e.q = eq;
      e.n = en;
      sb.push_back(e);
      pulse_start();
      wait_done(tag);
      repeat (3) @(negedge clk_50M);
   endtask

   initial begin
      longint ri;
      longint rq;
      int     n;

      // Reset state.
      repeat (3) @(negedge clk_50M);
      check("rst_busy", {63'd0, busy}, 0);
      check("rst_result_valid", {63'd0, result_valid}, 0);
      check("rst_timeout_err", {63'd0, timeout_err}, 0);
      check("rst_i_sum", i_sum, 0);
      check("rst_q_sum", q_sum, 0);
      check("rst_sample_cnt", {32'd0, sample_cnt}, 0);

      @(posedge clk_50M);
      #1 rst_n = 1'b1;
      refs_en = 1'b1;
      repeat (5) @(posedge clk_50M);

      data_mode = 0; measure("const", 0, 0, 16);
      data_mode = 1; measure("in_phase", 1600, 0, 16);
      data_mode = 2; measure("quad", 0, 1600, 16);
      data_mode = 3; measure("quad_inv", 0, -1600, 16);

      data_mode = 1; valid_toggle = 1'b1;
      measure("valid_gaps", 800, 0, 8);
      valid_toggle = 1'b0;

      // Per-phase random data including the most negative sample.
      for (int p = 0; p < 8; p++) tbl[p] = DW'($urandom_range(0, 4095));
      tbl[3] = -12'sd2048;
      ri = 0;
      rq = 0;
      for (int p = 0; p < 8; p++) begin
         ri += (p < 4) ? 2 * longint'(tbl[p]) : -2 * longint'(tbl[p]);
         rq += (p >= 2 && p < 6) ? 2 * longint'(tbl[p]) : -2 * longint'(tbl[p]);
      end
      data_mode = 4; measure("rand_table", ri, rq, 16);

      // Timeout with references held low.
      refs_en = 1'b0;
      repeat (3) @(posedge clk_50M);
      pulse_start();
      n = 0;
      while (tmo_count == 0 && n < 200) begin
         @(negedge clk_50M);
         n++;
      end
      check("timeout_seen", {32'd0, tmo_count}, 1);
      check("timeout_latency", tmo_cyc - (start_cyc + 1), 50);
      @(negedge clk_50M);
      check("timeout_busy", {63'd0, busy}, 0);
      check("timeout_i_kept", i_sum, ri);
      check("timeout_q_kept", q_sum, rq);
      refs_en = 1'b1;
      repeat (10) @(posedge clk_50M);

      // Second start while busy is ignored.
      data_mode = 1;
      begin
         exp_t e;
         e.i = 1600; e.q = 0; e.n = 16;
         sb.push_back(e);
      end
      pulse_start();
      repeat (5) @(posedge clk_50M);
      #1 start = 1'b1;
      @(posedge clk_50M);
      #1 start = 1'b0;
      wait_done("start_busy");
      repeat (20) @(negedge clk_50M);
      check("busy_after_ignored_start", {63'd0, busy}, 0);

      // Start coinciding with result_valid is ignored.
      begin
         exp_t e;
         e.i = 1600; e.q = 0; e.n = 16;
         sb.push_back(e);
      end
      pulse_start();
      n = 0;
      while (!result_valid && n < 100) begin
         @(negedge clk_50M);
         n++;
      end
      if (n >= 100) check("start_at_valid_wait_expired", 0, 1);
      start = 1'b1;
      @(posedge clk_50M);
      #1 start = 1'b0;
      @(negedge clk_50M);
      check("start_at_valid_busy", {63'd0, busy}, 0);
      repeat (5) @(negedge clk_50M);

      // Reset in the middle of accumulation.
      pulse_start();
      repeat (14) @(posedge clk_50M);
      #1;
      check("busy_mid_acc", {63'd0, busy}, 1);
      rst_n = 1'b0;
      #2;
      check("midrst_busy", {63'd0, busy}, 0);
      check("midrst_i_sum", i_sum, 0);
      check("midrst_q_sum", q_sum, 0);
      check("midrst_sample_cnt", {32'd0, sample_cnt}, 0);
      check("midrst_result_valid", {63'd0, result_valid}, 0);
      @(posedge clk_50M);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk_50M);
      measure("after_reset", 1600, 0, 16);

      check("total_timeouts", {32'd0, tmo_count}, 1);
      check("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
